i2c_target_regbank: RTL

// Synthesizable, parametrised I2C target (slave) that owns a DEPTH-byte register bank.
// It is the RTL successor to the behavioural i2c_if slave and sits on the I2CMB bus as the device-under-exchange.

---
 rtl/i2c_target_regbank.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_target_regbank.sv
// i2c_target_regbank
//   I2C target (slave) owning a DEPTH-byte register bank. The first byte of a
//   write sets the bank pointer, and later bytes are written at the pointer,
//   which then auto-increments. Reads stream bank[ptr] and auto-increment.
//   Inputs pass through a synchronizer and a stability filter. SCL stretching
//   after ACK bits is optional.
// Ports
//   clk_i, rst_i   system clock, synchronous active-high reset
//   scl_i, sda_i   resolved bus pin values
//   sda_o, scl_o   open-drain drives (0 = pull low, 1 = release)
//   stretch_i      request to hold SCL low after an ACK bit (STRETCH_EN=1)
//   start_o/stop_o 1-cycle pulses on START (incl. repeated) / STOP
//   addr_match_o   own address acknowledged; cleared by START/STOP
//   rx_valid_o     1-cycle pulse when a data byte is written; byte on rx_data_o
//   ptr_o          current bank pointer
module i2c_target_regbank #(
   parameter logic [6:0]  SLAVE_ADDR = 7'h44,
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned FILTER_LEN = 3,
   parameter bit          GCALL_EN   = 1'b1,
   parameter bit          STRETCH_EN = 1'b0
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     scl_i,
   input  logic                     sda_i,
   output logic                     sda_o,
   output logic                     scl_o,
   input  logic                     stretch_i,
   output logic                     start_o,
   output logic                     stop_o,
   output logic                     addr_match_o,
   output logic                     rx_valid_o,
   output logic [7:0]               rx_data_o,
   output logic [$clog2(DEPTH)-1:0] ptr_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(FILTER_LEN + 1);

   localparam logic [3:0] S_IDLE      = 4'd0;
   localparam logic [3:0] S_ADDR      = 4'd1;
   localparam logic [3:0] S_ADDR_ACK  = 4'd2;
   localparam logic [3:0] S_WR_PTR    = 4'd3;
   localparam logic [3:0] S_WR_DATA   = 4'd4;
   localparam logic [3:0] S_WR_ACK    = 4'd5;
   localparam logic [3:0] S_RD_DATA   = 4'd6;
   localparam logic [3:0] S_RD_ACK    = 4'd7;
   localparam logic [3:0] S_WAIT_STOP = 4'd8;

   // index 1 = SCL, index 0 = SDA
   logic [1:0]       sync1, sync2, filt, filt_d;
   logic [CNT_W-1:0] fcnt [2];

   logic [3:0]       state;
   logic [3:0]       bit_cnt;
   logic [6:0]       sr;
   logic [7:0]       tx_sr;
   logic [PTR_W-1:0] ptr;
   logic [7:0]       bank [DEPTH];
   logic             sda_q, scl_q, stretching, ack_phase, ptr_set, rw, mack;

   logic scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det;
   logic ack_end, bank_we, addr_hit;
   logic [7:0] rx_byte, bank_rd;

   // Filtered value follows the synchronized pin only after FILTER_LEN
   // consecutive cycles of disagreement.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync1  <= '1;
         sync2  <= '1;
         filt   <= '1;
         filt_d <= '1;
         for (int unsigned i = 0; i < 2; i++) fcnt[i] <= '0;
      end else begin
         sync1  <= {scl_i, sda_i};
         sync2  <= sync1;
         filt_d <= filt;
         for (int unsigned i = 0; i < 2; i++) begin
            if (sync2[i] == filt[i]) begin
               fcnt[i] <= '0;
            end else if (fcnt[i] == CNT_W'(FILTER_LEN - 1)) begin
               filt[i] <= sync2[i];
               fcnt[i] <= '0;
            end else begin
               fcnt[i] <= fcnt[i] + CNT_W'(1);
            end
         end
      end
   end

   assign scl_f     = filt[1];
   assign sda_f     = filt[0];
   assign scl_rise  = scl_f & ~filt_d[1];
   assign scl_fall  = ~scl_f & filt_d[1];
   assign start_det = scl_f & filt_d[1] & filt_d[0] & ~sda_f;
   assign stop_det  = scl_f & filt_d[1] & ~filt_d[0] & sda_f;

   assign rx_byte  = {sr, sda_f};
   assign bank_rd  = bank[ptr];
   assign addr_hit = (rx_byte[7:1] == SLAVE_ADDR) ||
                     (GCALL_EN && (rx_byte[7:1] == 7'd0) && !rx_byte[0]);
   // falling SCL edge that closes the 9th (ACK) clock of a byte
   assign ack_end  = scl_fall && !stretching &&
                     ((ack_phase && (state == S_ADDR_ACK || state == S_WR_ACK)) ||
                      (state == S_RD_ACK));
   assign bank_we  = !rst_i && !stretching && scl_rise &&
                     (state == S_WR_DATA) && (bit_cnt == 4'd7);

   always_ff @(posedge clk_i) begin
      if (bank_we) bank[ptr] <= rx_byte;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state        <= S_IDLE;
         bit_cnt      <= '0;
         sr           <= '0;
         tx_sr        <= '0;
         ptr          <= '0;
         sda_q        <= 1'b1;
         scl_q        <= 1'b1;
         stretching   <= 1'b0;
         ack_phase    <= 1'b0;
         ptr_set      <= 1'b0;
         rw           <= 1'b0;
         mack         <= 1'b0;
         start_o      <= 1'b0;
         stop_o       <= 1'b0;
         addr_match_o <= 1'b0;
         rx_valid_o   <= 1'b0;
         rx_data_o    <= '0;
      end else begin
         start_o    <= start_det;
         stop_o     <= stop_det;
         rx_valid_o <= 1'b0;
         if (stop_det) begin
            state        <= S_IDLE;
            sda_q        <= 1'b1;
            scl_q        <= 1'b1;
            stretching   <= 1'b0;
            ack_phase    <= 1'b0;
            ptr_set      <= 1'b0;
            addr_match_o <= 1'b0;
         end else if (start_det) begin
            state        <= S_ADDR;
            bit_cnt      <= '0;
            sda_q        <= 1'b1;
            scl_q        <= 1'b1;
            stretching   <= 1'b0;
            ack_phase    <= 1'b0;
            addr_match_o <= 1'b0;
         end else if (stretching) begin
            if (!stretch_i) begin
               scl_q      <= 1'b1;
               stretching <= 1'b0;
            end
         end else begin
            case (state)
               S_ADDR: if (scl_rise) begin
                  sr      <= rx_byte[6:0];
                  bit_cnt <= bit_cnt + 4'd1;
                  if (bit_cnt == 4'd7) begin
                     rw <= sda_f;
                     if (addr_hit) begin
                        state        <= S_ADDR_ACK;
                        addr_match_o <= 1'b1;
                     end else begin
                        state <= S_WAIT_STOP;
                     end
                  end
               end
               S_ADDR_ACK, S_WR_ACK: if (scl_fall) begin
                  // first fall opens the ACK bit, second fall closes it
                  if (!ack_phase) begin
                     sda_q     <= 1'b0;
                     ack_phase <= 1'b1;
                  end else begin
                     ack_phase <= 1'b0;
                     bit_cnt   <= '0;
                     if (state == S_ADDR_ACK && rw) begin
                        state <= S_RD_DATA;
                        sda_q <= bank_rd[7];
                        tx_sr <= {bank_rd[6:0], 1'b1};
                     end else begin
                        sda_q <= 1'b1;
                        state <= (state == S_WR_ACK || ptr_set) ? S_WR_DATA : S_WR_PTR;
                     end
                  end
               end
               S_WR_PTR: if (scl_rise) begin
                  sr      <= rx_byte[6:0];
                  bit_cnt <= bit_cnt + 4'd1;
                  if (bit_cnt == 4'd7) begin
                     ptr     <= rx_byte[PTR_W-1:0];
                     ptr_set <= 1'b1;
                     state   <= S_WR_ACK;
                  end
               end
               S_WR_DATA: if (scl_rise) begin
                  sr      <= rx_byte[6:0];
                  bit_cnt <= bit_cnt + 4'd1;
                  if (bit_cnt == 4'd7) begin
                     rx_data_o  <= rx_byte;
                     rx_valid_o <= 1'b1;
                     ptr        <= ptr + PTR_W'(1);
                     state      <= S_WR_ACK;
                  end
               end
               S_RD_DATA: begin
                  // bit 7 was launched on entry; each fall launches the next
                  if (scl_rise) bit_cnt <= bit_cnt + 4'd1;
                  if (scl_fall) begin
                     if (bit_cnt == 4'd8) begin
                        sda_q <= 1'b1;
                        state <= S_RD_ACK;
                     end else begin
                        sda_q <= tx_sr[7];
                        tx_sr <= {tx_sr[6:0], 1'b1};
                     end
                  end
               end
               S_RD_ACK: begin
                  if (scl_rise) begin
                     mack <= sda_f;
                     ptr  <= ptr + PTR_W'(1);
                  end
                  if (scl_fall) begin
                     if (!mack) begin
                        state   <= S_RD_DATA;
                        bit_cnt <= '0;
                        sda_q   <= bank_rd[7];
                        tx_sr   <= {bank_rd[6:0], 1'b1};
                     end else begin
                        state <= S_WAIT_STOP;
                        sda_q <= 1'b1;
                     end
                  end
               end
               S_IDLE, S_WAIT_STOP: sda_q <= 1'b1;
               default: state <= S_IDLE;
            endcase
            if (ack_end && STRETCH_EN && stretch_i) begin
               scl_q      <= 1'b0;
               stretching <= 1'b1;
            end
         end
      end
   end

   // reset releases the bus in the same cycle it is asserted
   assign sda_o = sda_q | rst_i;
   assign scl_o = scl_q | rst_i;
   assign ptr_o = ptr;

endmodule
